alu_exec_unit: RTL

- Execute-stage consumer of the 3-bit ALU control code produced by the ALU control decoder.
- Performs ADD, SUB, AND and OR in one registered cycle.
- Performs MUL as an iterative shift-add over WIDTH cycles and raises busy_o so the hazard/stall logic can freeze the pipeline.
- Result, zero flag and valid pulse are registered at the output.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_mul_seq.sv | 80 ++++++++
 rtl/alu_exec_unit.sv | 83 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control encodings for the control decoder and execute unit
// Contents:
//   ALU_* : 3-bit ALU control codes consumed by alu_exec_unit
//   ALUOP_* : 2-bit ALUOp encodings driven by the main decoder
//   mul_state_e : state of the iterative multiplier
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;

  localparam logic [1:0] ALUOP_LDST  = 2'b00;
  localparam logic [1:0] ALUOP_RTYPE = 2'b11;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_RUN  = 1'b1
  } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative shift-add multiplier, fixed WIDTH-cycle latency
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   start    : load a/b and begin (only honoured while idle)
//   a, b     : multiplicand, multiplier
//   flush    : abandon the running multiply without producing a result
//   done     : combinational, high in the cycle of the final iteration
//   busy     : multiply in progress
//   product  : low WIDTH bits of a*b, valid while done is high
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] product
);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_next;
  logic             last_iter;

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
  // The final iteration's sum is handed out directly so the result lands
  // in the output register on the same edge the FSM returns to idle.
  assign product   = acc_next;
  assign busy      = (state_q == MUL_RUN);

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      MUL_IDLE: if (start) state_d = MUL_RUN;
      MUL_RUN: begin
        if (flush) begin
          state_d = MUL_IDLE;
        end else if (last_iter) begin
          state_d = MUL_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == MUL_IDLE && start) begin
        cnt_q    <= '0;
        mcand_q  <= a;
        mplier_q <= b;
        acc_q    <= '0;
      end else if (state_q == MUL_RUN && !flush) begin
        // No early exit on a zero multiplier: latency stays fixed.
        cnt_q    <= cnt_q + 1'b1;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        acc_q    <= acc_next;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU: 1-cycle ADD/SUB/AND/OR, WIDTH+1-cycle MUL
// Ports:
//   clk_i, rst_i      : clock and synchronous active-high reset
//   flush_i           : drop the request / abort a running multiply
//   valid_i           : operation request
//   ALUCtrl_i         : 3-bit ALU control code (see alu_pkg)
//   data1_i, data2_i  : operands A and B
//   busy_o            : multiply running, requests ignored
//   valid_o           : one-cycle pulse when data_o/zero_o are new
//   data_o, zero_o    : registered result and result==0 flag
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  logic             accept, start_mul, single_op;
  logic             mul_done, mul_busy;
  logic [WIDTH-1:0] mul_product, alu_res;

  assign accept    = valid_i & ~mul_busy & ~flush_i;
  assign start_mul = accept & (ALUCtrl_i == ALU_MUL);
  assign single_op = accept & (ALUCtrl_i != ALU_MUL);
  assign busy_o    = mul_busy;

  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      ALU_ADD: alu_res = data1_i + data2_i;
      ALU_SUB: alu_res = data1_i - data2_i;
      ALU_AND: alu_res = data1_i & data2_i;
      ALU_OR:  alu_res = data1_i | data2_i;
      default: alu_res = '0;  // unused codes yield zero with zero flag set
    endcase
  end

  alu_mul_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk_i),
    .rst     (rst_i),
    .start   (start_mul),
    .a       (data1_i),
    .b       (data2_i),
    .flush   (flush_i),
    .done    (mul_done),
    .busy    (mul_busy),
    .product (mul_product)
  );

  // single_op and mul_done are exclusive: done implies busy, which blocks accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      zero_o  <= 1'b0;
    end else begin
      valid_o <= single_op | mul_done;
      if (single_op) begin
        data_o <= alu_res;
        zero_o <= (alu_res == '0);
      end else if (mul_done) begin
        data_o <= mul_product;
        zero_o <= (mul_product == '0);
      end
    end
  end

endmodule
